key_search_ctrl: RTL and testbench

Brute-force search sequencer for the RC4 cracking datapath. It sits directly downstream of the 22-bit key candidate generator. It requests each candidate with a one-cycle `start_key` pulse and hands the candidate to the RC4 decrypt core. It then scans the decrypted message RAM and drives `found_key` back to the generator when every plaintext byte is a lowercase letter or a space.

---
 rtl/key_search_ctrl.sv | 153 +++++++++++++++
 tb/tb_key_search_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_ctrl.sv
// Brute-force RC4 key search sequencer: requests candidates, launches the decrypt
// core, then scans the decrypted message for lowercase letters and spaces only.
module key_search_ctrl #(
    parameter int          MSG_LEN = 32,
    parameter logic [21:0] KEY_MAX = 22'h3FFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        start_key,
    input  logic        key_ready,
    input  logic [21:0] key_in,
    output logic        found_key,
    output logic        dec_start,
    output logic [23:0] dec_key,
    input  logic        dec_done,
    output logic [4:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic        exhausted,
    output logic [21:0] key_found,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE,
        REQ_KEY,
        WAIT_KEY,
        LAUNCH,
        WAIT_DEC,
        SCAN,
        FAIL,
        FOUND,
        EXHAUSTED
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(MSG_LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic [21:0] cur_key;
    logic [4:0]  chk_idx;
    logic        data_vld;
    logic        byte_ok;

    assign byte_ok = ((rd_data >= 8'h61) && (rd_data <= 8'h7A)) || (rd_data == 8'h20);
    assign dec_key = {2'b00, cur_key};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM read data lags the address by one cycle; data_vld masks the first SCAN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_key  <= '0;
            rd_addr  <= '0;
            chk_idx  <= '0;
            data_vld <= 1'b0;
        end else begin
            case (state)
                WAIT_KEY: begin
                    if (key_ready) begin
                        cur_key <= key_in;
                    end
                end
                WAIT_DEC: begin
                    if (dec_done) begin
                        rd_addr  <= '0;
                        chk_idx  <= '0;
                        data_vld <= 1'b0;
                    end
                end
                SCAN: begin
                    if (rd_addr != LAST_IDX) begin
                        rd_addr <= rd_addr + 5'd1;
                    end
                    if (data_vld) begin
                        chk_idx <= chk_idx + 5'd1;
                    end else begin
                        data_vld <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        start_key = 1'b0;
        dec_start = 1'b0;
        busy      = 1'b1;
        found_key = 1'b0;
        exhausted = 1'b0;
        key_found = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) begin
                    state_nxt = REQ_KEY;
                end
            end
            REQ_KEY: begin
                start_key = 1'b1;
                state_nxt = WAIT_KEY;
            end
            WAIT_KEY: begin
                if (key_ready) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                dec_start = 1'b1;
                state_nxt = WAIT_DEC;
            end
            WAIT_DEC: begin
                if (dec_done) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (data_vld) begin
                    if (!byte_ok) begin
                        state_nxt = FAIL;
                    end else if (chk_idx == LAST_IDX) begin
                        state_nxt = FOUND;
                    end
                end
            end
            FAIL: begin
                state_nxt = (cur_key == KEY_MAX) ? EXHAUSTED : REQ_KEY;
            end
            FOUND: begin
                busy      = 1'b0;
                found_key = 1'b1;
                key_found = cur_key;
            end
            EXHAUSTED: begin
                busy      = 1'b0;
                exhausted = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed self-checking bench for key_search_ctrl with a synchronous-read
// message RAM model and a simple candidate generator / decrypt core driven by tasks.
module tb_key_search_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        start_key;
    logic        key_ready;
    logic [21:0] key_in;
    logic        found_key;
    logic        dec_start;
    logic [23:0] dec_key;
    logic        dec_done;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        exhausted;
    logic [21:0] key_found;
    logic        busy;

    logic [7:0]  mem [32];

    int checks = 0;
    int errors = 0;

    int   start_cnt = 0;
    int   dec_cnt   = 0;
    int   viol      = 0;
    logic prev_start = 1'b0;
    logic prev_dec   = 1'b0;

    key_search_ctrl #(
        .MSG_LEN(32),
        .KEY_MAX(22'h3FFFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start_key (start_key),
        .key_ready (key_ready),
        .key_in    (key_in),
        .found_key (found_key),
        .dec_start (dec_start),
        .dec_key   (dec_key),
        .dec_done  (dec_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .exhausted (exhausted),
        .key_found (key_found),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

    // Pulse counters and invariant watchers, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            start_cnt  = 0;
            dec_cnt    = 0;
            prev_start = 1'b0;
            prev_dec   = 1'b0;
        end else begin
            if (start_key) start_cnt++;
            if (dec_start) dec_cnt++;
            if (start_key && prev_start) viol++;
            if (dec_start && prev_dec) viol++;
            prev_start = start_key;
            prev_dec   = dec_start;
        end
        if (found_key && exhausted) viol++;
        if (!found_key && (key_found != 22'd0)) viol++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        key_ready = 1'b0;
        dec_done  = 1'b0;
        key_in    = '0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic fill_valid();
        for (int i = 0; i < 32; i++) mem[i] = 8'h61;
    endtask

    task automatic give_key(input logic [21:0] key);
        key_ready = 1'b1;
        key_in    = key;
        tick(1);
        key_ready = 1'b0;
        checkOutput("dec_start", 32'(dec_start), 32'd1);
        checkOutput("dec_key", 32'(dec_key), 32'({2'b00, key}));
    endtask

    // Leaves the bench one cycle after dec_done (first SCAN cycle, d+1)
    task automatic finish_dec();
        tick(2);
        dec_done = 1'b1;
        tick(1);
        dec_done = 1'b0;
        checkOutput("rd_addr_zero", 32'(rd_addr), 32'd0);
    endtask

    task automatic applyStimulus(input logic [21:0] key);
        int n;
        n = 0;
        while (start_key !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput("start_key_seen", 32'(start_key), 32'd1);
        tick(1);
        give_key(key);
        finish_dec();
    endtask

    initial begin
        string       s;
        logic [7:0]  pat [3];
        logic [7:0]  bad_val [4];
        int          bad_pos [4];

        s = "the quick brown fox jumps over the lazy dog";
        pat[0] = 8'h61; pat[1] = 8'h7A; pat[2] = 8'h20;
        bad_val[0] = 8'h60; bad_val[1] = 8'h7B; bad_val[2] = 8'h1F; bad_val[3] = 8'h21;
        bad_pos[0] = 0;     bad_pos[1] = 10;    bad_pos[2] = 20;    bad_pos[3] = 31;
        fill_valid();

        // Reset values
        do_reset();
        checkOutput("rst_start_key", 32'(start_key), 32'd0);
        checkOutput("rst_dec_start", 32'(dec_start), 32'd0);
        checkOutput("rst_found", 32'(found_key), 32'd0);
        checkOutput("rst_exhausted", 32'(exhausted), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_dec_key", 32'(dec_key), 32'd0);
        checkOutput("rst_key_found", 32'(key_found), 32'd0);

        // Match on first candidate
        for (int i = 0; i < 32; i++) mem[i] = s[i];
        pulse_enable();
        checkOutput("t1_start_after_enable", 32'(start_key), 32'd1);
        applyStimulus(22'h000000);
        tick(32);
        checkOutput("t1_not_found_early", 32'(found_key), 32'd0);
        tick(1);
        checkOutput("t1_found_d34", 32'(found_key), 32'd1);
        checkOutput("t1_key_found", 32'(key_found), 32'd0);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_start_cnt", 32'(start_cnt), 32'd1);
        checkOutput("t1_dec_cnt", 32'(dec_cnt), 32'd1);

        // Early-abort chain
        do_reset();
        pulse_enable();
        fill_valid();
        mem[0] = 8'h41;
        applyStimulus(22'h000005);
        tick(2);
        checkOutput("t2_k5_fail_state", 32'(start_key), 32'd0);
        tick(1);
        checkOutput("t2_k5_restart", 32'(start_key), 32'd1);
        fill_valid();
        mem[31] = 8'h7B;
        applyStimulus(22'h000006);
        tick(33);
        checkOutput("t2_k6_fail_state", 32'(start_key), 32'd0);
        checkOutput("t2_k6_not_found", 32'(found_key), 32'd0);
        tick(1);
        checkOutput("t2_k6_restart", 32'(start_key), 32'd1);
        fill_valid();
        applyStimulus(22'h000007);
        tick(33);
        checkOutput("t2_found", 32'(found_key), 32'd1);
        checkOutput("t2_key_found", 32'(key_found), 32'h7);
        checkOutput("t2_start_cnt", 32'(start_cnt), 32'd3);
        checkOutput("t2_dec_cnt", 32'(dec_cnt), 32'd3);

        // Boundary bytes: passing pattern, then single-byte corruptions
        for (int i = 0; i < 32; i++) mem[i] = pat[i % 3];
        do_reset();
        pulse_enable();
        applyStimulus(22'h00000A);
        tick(33);
        checkOutput("t3_bnd_pass", 32'(found_key), 32'd1);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 32; i++) mem[i] = pat[i % 3];
            mem[bad_pos[b]] = bad_val[b];
            do_reset();
            pulse_enable();
            applyStimulus(22'h000001);
            tick(bad_pos[b] + 2);
            checkOutput("t3_bnd_fail_busy", 32'(busy), 32'd1);
            tick(1);
            checkOutput("t3_bnd_fail_restart", 32'(start_key), 32'd1);
            checkOutput("t3_bnd_fail_no_found", 32'(found_key), 32'd0);
        end

        // Exhaustion
        fill_valid();
        mem[0] = 8'h00;
        do_reset();
        pulse_enable();
        applyStimulus(22'h3FFFFF);
        tick(2);
        checkOutput("t4_fail_not_exh", 32'(exhausted), 32'd0);
        tick(1);
        checkOutput("t4_exhausted", 32'(exhausted), 32'd1);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        tick(10);
        checkOutput("t4_exh_hold", 32'(exhausted), 32'd1);
        checkOutput("t4_no_found", 32'(found_key), 32'd0);
        checkOutput("t4_start_cnt", 32'(start_cnt), 32'd1);

        // Reset mid-run during SCAN at byte 10
        fill_valid();
        do_reset();
        pulse_enable();
        applyStimulus(22'h000009);
        tick(11);
        checkOutput("t5_scan_addr", 32'(rd_addr), 32'd11);
        checkOutput("t5_scan_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(1);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("t5_rst_dec_key", 32'(dec_key), 32'd0);
        checkOutput("t5_rst_start", 32'(start_key), 32'd0);
        checkOutput("t5_rst_found", 32'(found_key), 32'd0);
        reset = 1'b0;
        tick(3);
        checkOutput("t5_idle_hold", 32'(busy), 32'd0);
        pulse_enable();
        checkOutput("t5_fresh_start", 32'(start_key), 32'd1);
        applyStimulus(22'h000002);
        tick(33);
        checkOutput("t5_found", 32'(found_key), 32'd1);
        checkOutput("t5_key_found", 32'(key_found), 32'h2);

        // Spurious strobes in IDLE, REQ_KEY and SCAN
        fill_valid();
        do_reset();
        key_ready = 1'b1;
        dec_done  = 1'b1;
        key_in    = 22'h0000AB;
        tick(1);
        key_ready = 1'b0;
        dec_done  = 1'b0;
        tick(1);
        checkOutput("t6_idle_busy", 32'(busy), 32'd0);
        checkOutput("t6_idle_dec_cnt", 32'(dec_cnt), 32'd0);
        pulse_enable();
        key_ready = 1'b1;
        dec_done  = 1'b1;
        key_in    = 22'h000111;
        tick(1);
        key_ready = 1'b0;
        dec_done  = 1'b0;
        checkOutput("t6_req_no_launch", 32'(dec_start), 32'd0);
        checkOutput("t6_req_busy", 32'(busy), 32'd1);
        give_key(22'h000020);
        finish_dec();
        tick(5);
        key_ready = 1'b1;
        dec_done  = 1'b1;
        enable    = 1'b1;
        tick(1);
        key_ready = 1'b0;
        dec_done  = 1'b0;
        enable    = 1'b0;
        tick(26);
        checkOutput("t6_not_found_early", 32'(found_key), 32'd0);
        tick(1);
        checkOutput("t6_found", 32'(found_key), 32'd1);
        checkOutput("t6_key_found", 32'(key_found), 32'h20);
        checkOutput("t6_dec_cnt", 32'(dec_cnt), 32'd1);
        checkOutput("t6_start_cnt", 32'(start_cnt), 32'd1);

        checkOutput("invariants", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
